// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for the chunked add/subtract sequencer.
// The slave side is the sequencer; the master side is the producer/consumer.
interface add_seq_if #(
  parameter int OPWIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [OPWIDTH-1:0] op_a;
  logic [OPWIDTH-1:0] op_b;
  logic               carry_in;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [OPWIDTH-1:0] sum;
  logic               carry_out;
  logic               overflow;
  logic               busy;

  modport slave (
    input  in_valid, op_a, op_b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport master (
    output in_valid, op_a, op_b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Multi-cycle OPWIDTH-bit add/subtract built from one CHUNK-bit adder slice,
// stepped LSB to MSB one chunk per clock with the carry held in a register.
module add_seq_ctrl #(
  parameter int OPWIDTH = 32,
  parameter int CHUNK   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  add_seq_if.slave  bus
);
  localparam int NCHUNK = OPWIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((OPWIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("add_seq_ctrl: OPWIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic               accept, step, last;
  logic               ready, valid, active;
  logic [OPWIDTH-1:0] a_q, b_q, sum_q;
  logic [IDXW-1:0]    idx_q;
  logic               carry_q, cout_q, ovf_q;
  logic [CHUNK-1:0]   slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_ovf;

  // Returns {overflow, carry_out, sum}; overflow is carry-in xor carry-out of the slice MSB.
  function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
    logic [CHUNK:0] s;
    logic           c_msb;
    s     = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];
    return {c_msb ^ s[CHUNK], s};
  endfunction

  assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q*CHUNK +: CHUNK];
  assign {slice_ovf, slice_cout, slice_sum} = slice_add(slice_a, slice_b, carry_q);
  assign last = (idx_q == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    valid    = 1'b0;
    active   = 1'b0;
    accept   = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        active = 1'b1;
        step   = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        active = 1'b1;
        valid  = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured once at accept; subtract stores ~B so the slice only ever adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.op_a;
      b_q <= bus.sub ? ~bus.op_b : bus.op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      carry_q <= bus.sub | bus.carry_in;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum;
      carry_q <= slice_cout;
      if (last) begin
        cout_q <= slice_cout;
        ovf_q  <= slice_ovf;
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.busy      = active;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl at 16/4, 8/8, 32/8 and 64/8; one instance
// is selected at a time and its outputs are muxed onto common 64-bit signals.
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        in_valid, out_ready, cin, sb;
  logic [63:0] a, b;

  always #5 clk = ~clk;

  add_seq_if #(.OPWIDTH(16)) if16();
  add_seq_if #(.OPWIDTH(8))  if8();
  add_seq_if #(.OPWIDTH(32)) if32();
  add_seq_if #(.OPWIDTH(64)) if64();

  add_seq_ctrl #(.OPWIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  add_seq_ctrl #(.OPWIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  add_seq_ctrl #(.OPWIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  add_seq_ctrl #(.OPWIDTH(64), .CHUNK(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

  assign if16.in_valid = in_valid && (sel == 2'd0);
  assign if8.in_valid  = in_valid && (sel == 2'd1);
  assign if32.in_valid = in_valid && (sel == 2'd2);
  assign if64.in_valid = in_valid && (sel == 2'd3);
  assign if16.op_a = a[15:0];  assign if16.op_b = b[15:0];
  assign if8.op_a  = a[7:0];   assign if8.op_b  = b[7:0];
  assign if32.op_a = a[31:0];  assign if32.op_b = b[31:0];
  assign if64.op_a = a;        assign if64.op_b = b;
  assign if16.carry_in = cin;  assign if16.sub = sb;  assign if16.out_ready = out_ready;
  assign if8.carry_in  = cin;  assign if8.sub  = sb;  assign if8.out_ready  = out_ready;
  assign if32.carry_in = cin;  assign if32.sub = sb;  assign if32.out_ready = out_ready;
  assign if64.carry_in = cin;  assign if64.sub = sb;  assign if64.out_ready = out_ready;

  logic        m_rdy, m_ov, m_cout, m_ovf, m_busy;
  logic [63:0] m_sum;
  int          w, nch;

  always_comb begin
    m_rdy = if16.in_ready; m_ov = if16.out_valid; m_sum = 64'(if16.sum);
    m_cout = if16.carry_out; m_ovf = if16.overflow; m_busy = if16.busy; w = 16; nch = 4;
    case (sel)
      2'd1: begin
        m_rdy = if8.in_ready; m_ov = if8.out_valid; m_sum = 64'(if8.sum);
        m_cout = if8.carry_out; m_ovf = if8.overflow; m_busy = if8.busy; w = 8; nch = 1;
      end
      2'd2: begin
        m_rdy = if32.in_ready; m_ov = if32.out_valid; m_sum = 64'(if32.sum);
        m_cout = if32.carry_out; m_ovf = if32.overflow; m_busy = if32.busy; w = 32; nch = 4;
      end
      2'd3: begin
        m_rdy = if64.in_ready; m_ov = if64.out_valid; m_sum = if64.sum;
        m_cout = if64.carry_out; m_ovf = if64.overflow; m_busy = if64.busy; w = 64; nch = 8;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: plain wide add of A + (sub ? ~B : B) + (sub ? 1 : cin); overflow from sign bits.
  function automatic exp_t model(int width, logic [63:0] x, logic [63:0] y, logic ci, logic s);
    exp_t        r;
    logic [63:0] mask, xx, yy;
    logic [64:0] full;
    mask   = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
    xx     = x & mask;
    yy     = (s ? ~y : y) & mask;
    full   = {1'b0, xx} + {1'b0, yy} + 65'(s ? 1'b1 : ci);
    r.sum  = full[63:0] & mask;
    r.cout = full[width];
    r.ovf  = (xx[width-1] == yy[width-1]) && (r.sum[width-1] != xx[width-1]);
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (sel=%0d)", tag, got, exp, sel);
    end
  endtask

  // Called at a negedge with the selected instance idle; returns at a negedge, idle again.
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic ci,
                        input logic s, input int stall, input bit scramble);
    exp_t        e;
    int          n;
    logic [63:0] hs;
    logic        hc, ho;
    a = x; b = y; cin = ci; sb = s;
    check_val("idle_rdy", 64'(m_rdy), 64'd1);
    sbq.push_back(model(w, x, y, ci, s));
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("run_busy_rdy", 64'({m_busy, m_rdy}), 64'b10);
    n = 0;
    while (!m_ov && n < 200) begin
      if (scramble) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom); sb = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check_val("latency", 64'(n), 64'(nch));
    if (stall > 0) begin
      hs = m_sum; hc = m_cout; ho = m_ovf;
      for (int i = 0; i < stall; i++) begin
        in_valid = (i == 1);
        @(negedge clk);
        check_val("hold_sum", m_sum, hs);
        check_val("hold_flags", 64'({m_cout, m_ovf}), 64'({hc, ho}));
        check_val("hold_vld_rdy", 64'({m_ov, m_rdy}), 64'b10);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    if (sbq.size() == 0) begin
      check_val("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      check_val("sum", m_sum, e.sum);
      check_val("carry_out", 64'(m_cout), 64'(e.cout));
      check_val("overflow", 64'(m_ovf), 64'(e.ovf));
    end
    @(negedge clk);
    check_val("post_idle", 64'({m_ov, m_rdy, m_busy}), 64'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sb = 1'b0;
    a = '0; b = '0;
    rst_n = 1'b0;
    #12;
    check_val("rst_vld_rdy_busy", 64'({m_ov, m_rdy, m_busy}), 64'b010);
    check_val("rst_sum", m_sum, 64'd0);
    check_val("rst_flags", 64'({m_cout, m_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 16/4 cases
    run_op(64'hFFFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(64'h7FFF, 64'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(64'h0005, 64'h0007, 1'b1, 1'b1, 0, 1'b0);
    run_op(64'h1234, 64'h00FF, 1'b1, 1'b0, 5, 1'b0);
    run_op(64'hA5A5, 64'h5A5A, 1'b0, 1'b0, 0, 1'b1);

    // Asynchronous reset during the second RUN cycle
    a = 64'h1111; b = 64'h2222; cin = 1'b0; sb = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("pre_rst_busy", 64'(m_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_vld_rdy_busy", 64'({m_ov, m_rdy, m_busy}), 64'b010);
    check_val("arst_sum", m_sum, 64'd0);
    check_val("arst_flags", 64'({m_cout, m_ovf}), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_op(64'h1234, 64'h4321, 1'b0, 1'b0, 0, 1'b0);

    // Boundary and random sweep on every width
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      run_op('1, 64'd1, 1'b0, 1'b0, 0, 1'b0);
      run_op('1, '1, 1'b1, 1'b0, 0, 1'b0);
      run_op(64'd0, 64'd1, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'h8000_0000_0000_0080 >> (64 - w) << (64 - w) >> (64 - w), 64'd1, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'h1357_9BDF_2468_ACE0, 64'h1357_9BDF_2468_ACE0, 1'b1, 1'b1, 1, 1'b0);
      for (int k = 0; k < 30; k++) begin
        run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0) ? 2 : 0, ($urandom_range(0, 3) == 0));
      end
    end

    if (sbq.size() != 0) check_val("sb_leftover", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
